edge_point_extract: RTL and testbench

//  Sits directly downstream of the edge-magnitude stage: consumes its Pixel/Frame/Line stream.

---
 rtl/hough_pkg.sv | 31 +++
 rtl/edge_point_extract_if.sv | 13 +
 rtl/edge_point_extract_point_fifo.sv | 54 +++++
 rtl/edge_point_extract.sv | 112 +++++++++++
 tb/tb_edge_point_extract.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/hough_pkg.sv
// Point record shared between the edge-point extractor and the Hough voter.
// An entry is either an edge pixel (x,y) or an end-of-frame marker.
package hough_pkg;

  localparam int COORD_W = 8;

  typedef struct packed {
    logic               eof;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  localparam point_t MARKER = '{eof: 1'b1, x: '0, y: '0};

  function automatic point_t make_marker(input logic [COORD_W-1:0] y_last);
    point_t m;
    m   = MARKER;
    m.y = y_last;
    return m;
  endfunction

  function automatic point_t make_point(input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y);
    point_t p;
    p.eof = 1'b0;
    p.x   = x;
    p.y   = y;
    return p;
  endfunction

endpackage

// File: rtl/edge_point_extract_if.sv
// Valid/ready point stream from the extractor (master) to the Hough voter (slave).
interface edge_point_extract_if;

  logic [hough_pkg::COORD_W-1:0] PointX;
  logic [hough_pkg::COORD_W-1:0] PointY;
  logic                          PointEof;
  logic                          PointValid;
  logic                          PointReady;

  modport master (output PointX, PointY, PointEof, PointValid, input PointReady);
  modport slave  (input PointX, PointY, PointEof, PointValid, output PointReady);

endinterface

// File: rtl/edge_point_extract_point_fifo.sv
// Synchronous first-word-fall-through FIFO of point_t entries.
// The writer guarantees room; reads while empty are ignored.
module point_fifo
  import hough_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic          wr_en,
  input  point_t        wr_data,
  input  logic          rd_en,
  output point_t        rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  point_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          rd_ok;

  assign rd_ok = rd_en && !empty;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/edge_point_extract.sv
// Thresholds the edge-magnitude stream, tracks pixel coordinates and queues
// edge points plus end-of-frame markers for the Hough voter.
module edge_point_extract
  import hough_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic [COORD_W-1:0] PixelIn,
  input  logic               FrameIn,
  input  logic               LineIn,
  input  logic [COORD_W-1:0] Width,
  input  logic [COORD_W-1:0] Threshold,
  output logic               Overflow,
  edge_point_extract_if.master points
);

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  logic [COORD_W-1:0] x_q, y_q, x_d, y_d;
  logic               armed_q, armed_d;
  logic               hit, marker;
  logic               s1_push_q;
  point_t             s1_entry_q;

  logic               pop, wr_en, drop;
  logic [AW:0]        count, eff_count;
  logic               full, empty;
  point_t             head;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    armed_d = armed_q;
    if (FrameIn) begin
      x_d     = '0;
      y_d     = '0;
      armed_d = 1'b1;
    end else if (LineIn) begin
      x_d = '0;
      if (y_q != COORD_MAX) y_d = y_q + COORD_W'(1);
    end else if (x_q != COORD_MAX) begin
      x_d = x_q + COORD_W'(1);
    end
  end

  // Column 0 and row 0 are filter border outputs and never qualify.
  assign hit = armed_d && (x_d != '0) && (x_d < Width) && (y_d != '0)
            && (PixelIn >= Threshold);
  assign marker = FrameIn && armed_q;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      x_q        <= '0;
      y_q        <= '0;
      armed_q    <= 1'b0;
      s1_push_q  <= 1'b0;
      s1_entry_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      armed_q    <= armed_d;
      s1_push_q  <= hit || marker;
      s1_entry_q <= marker ? make_marker(y_q) : make_point(x_d, y_d);
    end
  end

  // Admission sees the slot freed by a same-cycle pop; the last slot is kept for the marker.
  assign pop       = !empty && points.PointReady;
  assign eff_count = count - (AW+1)'(pop);

  always_comb begin
    wr_en = 1'b0;
    if (s1_push_q) begin
      if (s1_entry_q.eof) wr_en = !full || pop;
      else                wr_en = (eff_count < (AW+1)'(DEPTH-1));
    end
  end

  assign drop = s1_push_q && !wr_en;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)      Overflow <= 1'b0;
    else if (drop)    Overflow <= 1'b1;
    else if (FrameIn) Overflow <= 1'b0;
  end

  point_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .Clk     (Clk),
    .nReset  (nReset),
    .wr_en   (wr_en),
    .wr_data (s1_entry_q),
    .rd_en   (points.PointReady),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign points.PointValid = !empty;
  assign points.PointX     = head.x;
  assign points.PointY     = head.y;
  assign points.PointEof   = head.eof;

endmodule

// File: tb/tb_edge_point_extract.sv
// Directed bench for edge_point_extract: raster points, markers, overflow,
// threshold/border boundaries, toggling ready and mid-frame reset.
module tb_edge_point_extract;
  import hough_pkg::*;

  logic       Clk = 1'b0;
  logic       nReset;
  logic [7:0] PixelIn, Width, Threshold;
  logic       FrameIn, LineIn, Overflow;

  edge_point_extract_if ifc();

  int     n_checks = 0;
  int     n_fails  = 0;
  point_t rx[$];
  bit     valid_seen;

  edge_point_extract #(.DEPTH(16), .AW(4)) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .PixelIn   (PixelIn),
    .FrameIn   (FrameIn),
    .LineIn    (LineIn),
    .Width     (Width),
    .Threshold (Threshold),
    .Overflow  (Overflow),
    .points    (ifc)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] p, input logic f, input logic l);
    PixelIn = p;
    FrameIn = f;
    LineIn  = l;
    tick();
    PixelIn = 8'd0;
    FrameIn = 1'b0;
    LineIn  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'd0, 1'b0, 1'b0);
  endtask

  function automatic point_t head();
    return '{eof: ifc.PointEof, x: ifc.PointX, y: ifc.PointY};
  endfunction

  function automatic point_t pt(input logic eof, input int x, input int y);
    return '{eof: eof, x: 8'(x), y: 8'(y)};
  endfunction

  task automatic pop_check(input string tag, input point_t exp);
    check({tag, ".valid"}, 32'(ifc.PointValid), 32'd1);
    check(tag, 32'(head()), 32'(exp));
    ifc.PointReady = 1'b1;
    tick();
    ifc.PointReady = 1'b0;
  endtask

  initial begin
    nReset         = 1'b0;
    PixelIn        = 8'd0;
    FrameIn        = 1'b0;
    LineIn         = 1'b0;
    Width          = 8'd4;
    Threshold      = 8'd10;
    ifc.PointReady = 1'b0;
    tick();
    tick();
    check("reset.valid", 32'(ifc.PointValid), 32'd0);
    check("reset.x", 32'(ifc.PointX), 32'd0);
    check("reset.y", 32'(ifc.PointY), 32'd0);
    check("reset.eof", 32'(ifc.PointEof), 32'd0);
    check("reset.ovf", 32'(Overflow), 32'd0);
    nReset = 1'b1;

    // Test 1: 3 lines of Width=4, all pixels above threshold.
    drive(8'd20, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(8'd20, 1'b0, 1'b0);
    for (int l = 0; l < 2; l++) begin
      drive(8'd20, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) drive(8'd20, 1'b0, 1'b0);
    end
    idle(2);
    check("t1.ovf", 32'(Overflow), 32'd0);
    for (int y = 1; y <= 2; y++)
      for (int x = 1; x <= 3; x++)
        pop_check($sformatf("t1.pt%0d_%0d", x, y), pt(1'b0, x, y));
    check("t1.drained", 32'(ifc.PointValid), 32'd0);

    // Test 2: closing FrameIn emits marker with 2-cycle latency.
    drive(8'd0, 1'b1, 1'b0);
    check("t2.lat1", 32'(ifc.PointValid), 32'd0);
    idle(1);
    pop_check("t2.marker", pt(1'b1, 0, 2));
    check("t2.drained", 32'(ifc.PointValid), 32'd0);

    // Test 3: 20 hits with consumer stalled; 15 stored, marker takes the reserved slot.
    Width = 8'd21;
    drive(8'd20, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive(8'd20, 1'b0, 1'b0);
    idle(2);
    check("t3.ovf_set", 32'(Overflow), 32'd1);
    Width = 8'd4;
    drive(8'd0, 1'b1, 1'b0);
    check("t3.ovf_clr", 32'(Overflow), 32'd0);
    idle(1);
    check("t3.ovf_stay", 32'(Overflow), 32'd0);
    for (int x = 1; x <= 15; x++) pop_check($sformatf("t3.pt%0d", x), pt(1'b0, x, 1));
    pop_check("t3.marker", pt(1'b1, 0, 1));
    check("t3.drained", 32'(ifc.PointValid), 32'd0);

    // Test 4: threshold and border boundaries (Width=4, Thr=10).
    drive(8'd20, 1'b0, 1'b0);
    drive(8'd20, 1'b0, 1'b1);
    drive(8'd9, 1'b0, 1'b0);
    drive(8'd10, 1'b0, 1'b0);
    drive(8'd255, 1'b0, 1'b0);
    drive(8'd255, 1'b0, 1'b0);
    idle(2);
    pop_check("t4.at_thr", pt(1'b0, 2, 1));
    pop_check("t4.above", pt(1'b0, 3, 1));
    check("t4.no_more", 32'(ifc.PointValid), 32'd0);

    // Test 5: PointReady toggling every cycle during continuous hits.
    Width = 8'd12;
    for (int i = 0; i < 40; i++) begin
      FrameIn        = (i == 0);
      LineIn         = (i == 1);
      PixelIn        = (i >= 1 && i <= 12) ? 8'd50 : 8'd0;
      ifc.PointReady = i[0];
      if (ifc.PointValid && ifc.PointReady) rx.push_back(head());
      tick();
    end
    FrameIn        = 1'b0;
    LineIn         = 1'b0;
    PixelIn        = 8'd0;
    ifc.PointReady = 1'b0;
    check("t5.count", 32'(rx.size()), 32'd12);
    if (rx.size() == 12) begin
      check("t5.marker", 32'(rx[0]), 32'(pt(1'b1, 0, 1)));
      for (int k = 1; k <= 11; k++)
        check($sformatf("t5.pt%0d", k), 32'(rx[k]), 32'(pt(1'b0, k, 1)));
    end
    check("t5.drained", 32'(ifc.PointValid), 32'd0);

    // Test 6: asynchronous reset mid-frame with 5 entries buffered.
    drive(8'd50, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(8'd50, 1'b0, 1'b0);
    idle(2);
    check("t6.pre_valid", 32'(ifc.PointValid), 32'd1);
    check("t6.pre_head", 32'(head()), 32'(pt(1'b0, 1, 2)));
    nReset = 1'b0;
    #2;
    check("t6.rst_valid", 32'(ifc.PointValid), 32'd0);
    check("t6.rst_head", 32'(head()), 32'd0);
    check("t6.rst_ovf", 32'(Overflow), 32'd0);
    #2;
    nReset = 1'b1;
    valid_seen = 1'b0;
    drive(8'd50, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(8'd50, 1'b0, 1'b0);
      valid_seen |= ifc.PointValid;
    end
    drive(8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      valid_seen |= ifc.PointValid;
    end
    check("t6.silent", 32'(valid_seen), 32'd0);
    drive(8'd50, 1'b0, 1'b1);
    drive(8'd50, 1'b0, 1'b0);
    check("t6.lat1", 32'(ifc.PointValid), 32'd0);
    idle(1);
    pop_check("t6.first_pt", pt(1'b0, 1, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
